lc3_dual_mem: RTL and testbench
===============================

# lc3_dual_mem

Parametrised dual-port memory responder for the LC-3 processor: one read-only instruction-fetch port and one read/write data port share a single word-addressed array behind a common arbiter. Generalises the single-port, fixed-latency memory used by the testbench environment: configurable width, depth, wait states and arbitration mode, plus out-of-range error reporting and an access counter. Sits between the LC-3 datapath's fetch/memory stages and the memory array.

## Interface

- ADDR_W, 16, address width of both ports
- DATA_W, 16, word width
- DEPTH_LOG2, 10, array holds 2**DEPTH_LOG2 words (DEPTH_LOG2 <= ADDR_W)
- WAIT_STATES, 2, extra cycles per access, 0..15
- ARB_MODE, 0, 0 = fixed data-port priority, 1 = round-robin

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level, held until i_done
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid with i_done, held afterwards
- i_done  out  1  one-cycle completion pulse
- i_err  out  1  fetch address out of range, valid with i_done
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read word, valid with d_done, held afterwards
- d_done  out  1  one-cycle completion pulse
- d_err  out  1  data address out of range, valid with d_done
- busy  out  1  high in any state other than IDLE
- acc_count  out  32  completed accesses, both ports

## Operation

- FSM: IDLE -> WAIT (skipped if WAIT_STATES=0) -> DONE -> RECOVER -> IDLE.
- IDLE: sample requests. ARB_MODE=0: d_req wins. ARB_MODE=1: on contention grant the port not granted last; last_grant resets to instruction port (first contention goes to data). Single request granted directly.
- Grant latches port id, addr, we, wdata; later input changes ignored until RECOVER ends.
- WAIT: down-counter loaded with WAIT_STATES, leaves at zero.
- Entering DONE: array read or write performed. Instruction port never writes.
- DONE: assert granted port's done for exactly one cycle; rdata updated (write: d_rdata unchanged).
- RECOVER: one cycle, all requests ignored; requester must drop req here.
- Out of range (addr >= 2**DEPTH_LOG2): write suppressed, rdata = 0, err = 1 with done. err low otherwise.
- acc_count increments on every done (errors included), wraps 2**32-1 -> 0.
- Array contents not cleared by reset.

## Timing

- Reset values: i_rdata, d_rdata = 0; i_done, d_done, i_err, d_err, busy = 0; acc_count = 0; FSM IDLE; counter 0.
- Request seen in cycle 0 (IDLE) -> done high in cycle WAIT_STATES+1 -> RECOVER cycle WAIT_STATES+2 -> IDLE cycle WAIT_STATES+3. Throughput: one access per WAIT_STATES+3 cycles.
- busy high from cycle 1 through RECOVER inclusive.
- Reset asserted during WAIT: access aborted, no write, no done, acc_count not incremented. Reset during DONE: write already committed.
- Simultaneous req on both ports: loser keeps req high and is granted in the next IDLE cycle (ARB_MODE=1 guarantees this; ARB_MODE=0 only if d_req low).

## Test plan

- WAIT_STATES=2: d write 0x1234 @0x0010, then i fetch @0x0010 -> d_done in cycle 3, i_done in cycle 3 of its request, i_rdata = 0x1234, acc_count = 2.
- WAIT_STATES=0: back-to-back data reads held high -> d_done every 3 cycles, busy low only in IDLE cycles.
- Both ports request continuously, ARB_MODE=1 -> grants alternate D, I, D, I; ARB_MODE=0 -> instruction port starved, i_done never seen.
- DEPTH_LOG2=10, d write 0xBEEF @0x0400 then read @0x0000 -> d_err=1 on write, no array change, address 0 reads previous value.
- Reset pulsed during WAIT of write 0xAAAA @0x0020 -> no d_done, acc_count = 0, later read @0x0020 returns old contents.
- Preload acc_count to 0xFFFFFFFF via 2**32-1 accesses (force in sim) then one access -> acc_count = 0.

Source files
------------

// File: rtl/lc3_dual_mem.sv
// lc3_dual_mem
// Dual-port memory responder for the LC-3 datapath. A read-only instruction
// fetch port (i_*) and a read/write data port (d_*) share one word-addressed
// array through a single arbiter, so only one access is in flight at a time.
//
// States:
//   IDLE    | sample requests, grant one port
//   WAIT    | wait-state down-counter running
//   DONE    | done pulse on granted port, rdata/err valid
//   RECOVER | one dead cycle, requests ignored
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_req/i_addr                 fetch request (level) and address
//   i_rdata/i_done/i_err         fetched word, completion pulse, range error
//   d_req/d_we/d_addr/d_wdata    data request, write enable, address, data
//   d_rdata/d_done/d_err         read word, completion pulse, range error
//   busy                         high whenever not in IDLE
//   acc_count                    completed accesses on both ports (wraps)
module lc3_dual_mem #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2,
  parameter int ARB_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              busy,
  output logic [31:0]       acc_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RECOVER} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                g_port;      // 1 = data port
  logic [ADDR_W-1:0]   g_addr;
  logic                g_we;
  logic [DATA_W-1:0]   g_wdata;
  logic                last_grant;  // 1 = data port got the previous grant

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                req_any;
  logic                grant_d;
  logic                go_done;
  logic                acc_port;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_we;
  logic [DATA_W-1:0]   acc_wdata;
  logic                in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                mem_we;

  always_comb begin
    req_any = i_req | d_req;
    if (ARB_MODE == 0) grant_d = d_req;
    else               grant_d = d_req & (~i_req | ~last_grant);

    // With zero wait states the access happens on the grant edge itself, so
    // the array sees the live request rather than the latched copy.
    go_done = ((state == S_IDLE) && req_any && (WAIT_STATES == 0)) ||
              ((state == S_WAIT) && (cnt == 4'd1));

    if (state == S_IDLE) begin
      acc_port  = grant_d;
      acc_addr  = grant_d ? d_addr : i_addr;
      acc_we    = grant_d & d_we;
      acc_wdata = d_wdata;
    end else begin
      acc_port  = g_port;
      acc_addr  = g_addr;
      acc_we    = g_we;
      acc_wdata = g_wdata;
    end

    in_range = ((acc_addr >> DEPTH_LOG2) == '0);
    idx      = acc_addr[DEPTH_LOG2-1:0];
    mem_we   = go_done & acc_we & in_range;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= acc_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      g_port     <= 1'b0;
      g_addr     <= '0;
      g_we       <= 1'b0;
      g_wdata    <= '0;
      last_grant <= 1'b0;
      i_rdata    <= '0;
      i_done     <= 1'b0;
      i_err      <= 1'b0;
      d_rdata    <= '0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      busy       <= 1'b0;
      acc_count  <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_err  <= 1'b0;
      d_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_any) begin
            g_port     <= grant_d;
            g_addr     <= grant_d ? d_addr : i_addr;
            g_we       <= grant_d & d_we;
            g_wdata    <= d_wdata;
            last_grant <= grant_d;
            busy       <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: state <= S_RECOVER;
        S_RECOVER: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (go_done) begin
        acc_count <= acc_count + 32'd1;
        if (acc_port) begin
          d_done <= 1'b1;
          d_err  <= ~in_range;
          // A write leaves the last read word on d_rdata.
          if (!acc_we) d_rdata <= in_range ? mem[idx] : '0;
        end else begin
          i_done  <= 1'b1;
          i_err   <= ~in_range;
          i_rdata <= in_range ? mem[idx] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lc3_dual_mem.sv
module tb_lc3_dual_mem;

  typedef struct packed {
    logic        port;    // 1 = data port
    logic        chk_rd;
    logic [15:0] rdata;
    logic        err;
    logic [31:0] acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] mdl_acc_a = '0;
  logic [15:0] mdl_drd_a = '0;
  logic [31:0] mdl_acc_b = '0;

  // dut_a: WAIT_STATES=2, round-robin
  logic        rst0;
  logic        a_i_req, a_d_req, a_d_we;
  logic [15:0] a_i_addr, a_d_addr, a_d_wdata;
  logic [15:0] a_i_rdata, a_d_rdata;
  logic        a_i_done, a_i_err, a_d_done, a_d_err, a_busy;
  logic [31:0] a_acc;

  // dut_b: WAIT_STATES=0, fixed data priority
  logic        rst1;
  logic        b_i_req, b_d_req, b_d_we;
  logic [15:0] b_i_addr, b_d_addr, b_d_wdata;
  logic [15:0] b_i_rdata, b_d_rdata;
  logic        b_i_done, b_i_err, b_d_done, b_d_err, b_busy;
  logic [31:0] b_acc;

  lc3_dual_mem #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_STATES(2), .ARB_MODE(1)) dut_a (
    .clk(clk), .rst(rst0),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_done(a_i_done), .i_err(a_i_err),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_done(a_d_done), .d_err(a_d_err),
    .busy(a_busy), .acc_count(a_acc)
  );

  lc3_dual_mem #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_STATES(0), .ARB_MODE(0)) dut_b (
    .clk(clk), .rst(rst1),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_done(b_i_done), .i_err(b_i_err),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_done(b_d_done), .d_err(b_d_err),
    .busy(b_busy), .acc_count(b_acc)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop one expected completion per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (a_i_done || a_d_done) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_done: got i_done=%0b d_done=%0b expected none (t=%0t)",
                 a_i_done, a_d_done, $time);
      end else begin
        e = qa.pop_front();
        chk("a_port", 64'({a_i_done, a_d_done}), e.port ? 64'(1) : 64'(2));
        if (e.chk_rd) chk("a_rdata", 64'(e.port ? a_d_rdata : a_i_rdata), 64'(e.rdata));
        chk("a_err", 64'(e.port ? a_d_err : a_i_err), 64'(e.err));
        chk("a_acc", 64'(a_acc), 64'(e.acc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_i_done || b_d_done) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_done: got i_done=%0b d_done=%0b expected none (t=%0t)",
                 b_i_done, b_d_done, $time);
      end else begin
        e = qb.pop_front();
        chk("b_port", 64'({b_i_done, b_d_done}), e.port ? 64'(1) : 64'(2));
        if (e.chk_rd) chk("b_rdata", 64'(e.port ? b_d_rdata : b_i_rdata), 64'(e.rdata));
        chk("b_err", 64'(e.port ? b_d_err : b_i_err), 64'(e.err));
        chk("b_acc", 64'(b_acc), 64'(e.acc));
      end
    end
  end

  function automatic exp_t mk(input logic port, input logic chk_rd, input logic [15:0] rd,
                              input logic err, input logic [31:0] acc);
    exp_t e;
    e.port = port; e.chk_rd = chk_rd; e.rdata = rd; e.err = err; e.acc = acc;
    return e;
  endfunction

  // One access on dut_a; expects done in cycle WAIT_STATES+1 = 3.
  task automatic a_access(input bit is_d, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rd_exp,
                          input bit err_exp, input string nm);
    exp_t e;
    int k;
    mdl_acc_a = mdl_acc_a + 32'd1;
    if (is_d && we) begin
      e = mk(1'b1, !err_exp, mdl_drd_a, err_exp, mdl_acc_a);
    end else begin
      e = mk(is_d, 1'b1, err_exp ? 16'h0 : rd_exp, err_exp, mdl_acc_a);
      if (is_d) mdl_drd_a = e.rdata;
    end
    qa.push_back(e);
    if (is_d) begin
      a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
    end else begin
      a_i_req = 1'b1; a_i_addr = addr;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk({nm, "_busy1"}, 64'(a_busy), 64'(1));
    end while (!(a_i_done || a_d_done) && k < 20);
    chk({nm, "_lat"}, 64'(k), 64'(3));
    a_d_req = 1'b0;
    a_i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_idle_busy"}, 64'(a_busy), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, i_seen;
    rst0 = 1'b1; rst1 = 1'b1;
    a_i_req = 0; a_d_req = 0; a_d_we = 0; a_i_addr = 0; a_d_addr = 0; a_d_wdata = 0;
    b_i_req = 0; b_d_req = 0; b_d_we = 0; b_i_addr = 0; b_d_addr = 0; b_d_wdata = 0;
    @(negedge clk);
    @(negedge clk);
    chk("a_reset_outs", 64'({a_i_rdata, a_d_rdata, a_i_done, a_d_done, a_i_err, a_d_err, a_busy}), 64'(0));
    chk("a_reset_acc", 64'(a_acc), 64'(0));
    chk("b_reset_outs", 64'({b_i_rdata, b_d_rdata, b_i_done, b_d_done, b_i_err, b_d_err, b_busy}), 64'(0));
    chk("b_reset_acc", 64'(b_acc), 64'(0));
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // ---------------- dut_a ----------------
    a_access(1, 1, 16'h0010, 16'h1234, 16'h0, 0, "a_wr10");
    a_access(0, 0, 16'h0010, 16'h0,    16'h1234, 0, "a_if10");
    chk("a_acc_two", 64'(a_acc), 64'(2));

    a_access(1, 1, 16'h0000, 16'h5A5A, 16'h0, 0, "a_wr00");
    a_access(1, 1, 16'h0400, 16'hBEEF, 16'h0, 1, "a_wr_oor");
    a_access(1, 0, 16'h0000, 16'h0, 16'h5A5A, 0, "a_rd00");
    a_access(0, 0, 16'hFFFF, 16'h0, 16'h0, 1, "a_if_oor");
    a_access(1, 1, 16'h0020, 16'h1111, 16'h0, 0, "a_wr20");

    // Reset during WAIT aborts the write.
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 16'h0020; a_d_wdata = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    chk("a_busy_wait", 64'(a_busy), 64'(1));
    rst0 = 1'b1;
    mdl_acc_a = '0;
    mdl_drd_a = '0;
    @(negedge clk);
    a_d_req = 1'b0;
    rst0 = 1'b0;
    @(negedge clk);
    chk("a_abort_acc", 64'(a_acc), 64'(0));
    chk("a_abort_busy", 64'(a_busy), 64'(0));

    // Contention, round-robin from reset: D, I, D, I.
    for (int j = 0; j < 4; j++) begin
      mdl_acc_a = mdl_acc_a + 32'd1;
      if (j % 2 == 0) qa.push_back(mk(1'b1, 1'b1, 16'h1111, 1'b0, mdl_acc_a));
      else            qa.push_back(mk(1'b0, 1'b1, 16'h1234, 1'b0, mdl_acc_a));
    end
    mdl_drd_a = 16'h1111;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'h0020;
    a_i_req = 1'b1; a_i_addr = 16'h0010;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (a_i_done || a_d_done) n++;
    end
    a_d_req = 1'b0; a_i_req = 1'b0;
    chk("a_alt_count", 64'(n), 64'(4));
    @(negedge clk);
    @(negedge clk);

    // acc_count wrap.
    force dut_a.acc_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_a.acc_count;
    @(negedge clk);
    chk("a_acc_preload", 64'(a_acc), 64'(32'hFFFF_FFFF));
    mdl_acc_a = 32'hFFFF_FFFF;
    a_access(0, 0, 16'h0010, 16'h0, 16'h1234, 0, "a_wrap");
    chk("a_acc_wrapped", 64'(a_acc), 64'(0));

    // ---------------- dut_b ----------------
    mdl_acc_b = mdl_acc_b + 32'd1;
    qb.push_back(mk(1'b1, 1'b1, 16'h0000, 1'b0, mdl_acc_b));
    b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 16'h0005; b_d_wdata = 16'hC0DE;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!b_d_done && k < 10);
    chk("b_wr_lat", 64'(k), 64'(1));
    b_d_req = 1'b0; b_d_we = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Back-to-back reads: done every 3 cycles, busy low only in IDLE.
    for (int j = 0; j < 4; j++) begin
      mdl_acc_b = mdl_acc_b + 32'd1;
      qb.push_back(mk(1'b1, 1'b1, 16'hC0DE, 1'b0, mdl_acc_b));
    end
    b_d_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("b_b2b_done", 64'(b_d_done), 64'(c % 3 == 1));
      chk("b_b2b_busy", 64'(b_busy), 64'(c % 3 != 0));
    end
    b_d_req = 1'b0;
    @(negedge clk);

    // Fixed priority: instruction port starved while d_req held.
    for (int j = 0; j < 5; j++) begin
      mdl_acc_b = mdl_acc_b + 32'd1;
      qb.push_back(mk(1'b1, 1'b1, 16'hC0DE, 1'b0, mdl_acc_b));
    end
    b_d_req = 1'b1;
    b_i_req = 1'b1; b_i_addr = 16'h0005;
    i_seen = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (b_i_done) i_seen++;
      chk("b_starve_ddone", 64'(b_d_done), 64'(c % 3 == 1));
    end
    b_d_req = 1'b0;
    chk("b_i_starved", 64'(i_seen), 64'(0));

    // Instruction port gets through once d_req drops.
    mdl_acc_b = mdl_acc_b + 32'd1;
    qb.push_back(mk(1'b0, 1'b1, 16'hC0DE, 1'b0, mdl_acc_b));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!b_i_done && k < 10);
    chk("b_if_lat", 64'(k), 64'(1));
    b_i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_acc_final", 64'(b_acc), 64'(11));

    repeat (4) @(negedge clk);
    chk("a_queue_empty", 64'(qa.size()), 64'(0));
    chk("b_queue_empty", 64'(qb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
